// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register offsets, control layout and byte-lane helper for the machine timer
package timer_pkg;

  localparam logic [2:0] TMR_MTIME_LO   = 3'd0;
  localparam logic [2:0] TMR_MTIME_HI   = 3'd1;
  localparam logic [2:0] TMR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] TMR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] TMR_CTRL       = 3'd4;
  localparam logic [2:0] TMR_STATUS     = 3'd5;
  localparam logic [2:0] TMR_PRESCALE   = 3'd6;
  localparam logic [2:0] TMR_RSVD       = 3'd7;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int CTRL_PERIODIC_BIT = 2;
  localparam int STATUS_PEND_BIT   = 0;

  localparam logic [3:0] TMR_BASE_NIBBLE = 4'hA;

  typedef struct packed {
    logic periodic;
    logic irq_en;
    logic en;
  } tmr_ctrl_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - free-running divider producing a one-cycle tick every prescale+1 enabled cycles
module timer_prescaler #(
  parameter int PRESC_WID = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [PRESC_WID-1:0] prescale_i,
  output logic                 tick_o
);

  logic [PRESC_WID-1:0] presc_cnt_q;
  logic [PRESC_WID-1:0] presc_cnt_d;
  logic                 at_top;

  assign at_top = (presc_cnt_q == prescale_i);
  assign tick_o = en_i & at_top;

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (clear_i) begin
      presc_cnt_d = '0;
    end else if (en_i) begin
      presc_cnt_d = at_top ? '0 : presc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - memory-mapped 64-bit machine timer with compare, sticky pending and level irq
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int          PRESC_WID = 16,
  parameter logic [63:0] RST_CMP   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_i,
  input  logic        system_bus_en,
  input  logic        system_bus_rdwr,
  input  logic [3:0]  system_bus_mask,
  input  logic [31:0] system_bus_addr,
  input  logic [31:0] system_bus_wr_data,
  output logic [31:0] system_bus_rd_data,
  output logic        irq_o
);

  tmr_ctrl_t            ctrl_q, ctrl_d;
  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          mtimecmp_q, mtimecmp_d;
  logic                 pending_q, pending_d;
  logic [PRESC_WID-1:0] prescale_q, prescale_d;
  logic [31:0]          hi_shadow_q, hi_shadow_d;
  logic [31:0]          rd_data_q, rd_data_d;
  logic                 irq_q, irq_d;

  logic        acc, wr_en, rd_en;
  logic [2:0]  offset;
  logic        wr_ctrl, wr_presc, w1c;
  logic        en_eff, tick, reload, match;
  logic [63:0] mtime_inc;
  logic [31:0] presc_ext, presc_merge;
  logic        unused_ok;

  assign acc    = system_bus_en & sel_i;
  assign wr_en  = acc & system_bus_rdwr;
  assign rd_en  = acc & ~system_bus_rdwr;
  assign offset = system_bus_addr[4:2];

  assign wr_ctrl  = wr_en && (offset == TMR_CTRL);
  assign wr_presc = wr_en && (offset == TMR_PRESCALE);
  assign w1c      = wr_en && (offset == TMR_STATUS) && system_bus_mask[0]
                    && system_bus_wr_data[STATUS_PEND_BIT];

  // Clearing en must stop a tick on the very edge it is written.
  assign en_eff = ctrl_q.en & ~(wr_ctrl & system_bus_mask[0] & ~system_bus_wr_data[CTRL_EN_BIT]);

  timer_prescaler #(
    .PRESC_WID (PRESC_WID)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_eff),
    .clear_i    (wr_presc),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );

  assign mtime_inc = mtime_q + 64'd1;
  assign reload    = tick & ctrl_q.periodic & (mtime_inc == mtimecmp_q);
  assign match     = ctrl_q.en & (mtime_q >= mtimecmp_q);

  assign presc_ext   = 32'(prescale_q);
  assign presc_merge = byte_merge(presc_ext, system_bus_wr_data, system_bus_mask);
  assign unused_ok   = ^{system_bus_addr[31:5], system_bus_addr[1:0], presc_merge};

  always_comb begin
    mtime_d = mtime_q;
    if (tick) begin
      mtime_d = reload ? 64'd0 : mtime_inc;
    end
    // A software write replaces the whole next value; unwritten bytes keep the pre-tick value.
    if (wr_en && offset == TMR_MTIME_LO) begin
      mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], system_bus_wr_data, system_bus_mask)};
    end else if (wr_en && offset == TMR_MTIME_HI) begin
      mtime_d = {byte_merge(mtime_q[63:32], system_bus_wr_data, system_bus_mask), mtime_q[31:0]};
    end

    mtimecmp_d = mtimecmp_q;
    if (wr_en && offset == TMR_MTIMECMP_LO) begin
      mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], system_bus_wr_data, system_bus_mask);
    end else if (wr_en && offset == TMR_MTIMECMP_HI) begin
      mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], system_bus_wr_data, system_bus_mask);
    end

    ctrl_d = ctrl_q;
    if (wr_ctrl && system_bus_mask[0]) begin
      ctrl_d = tmr_ctrl_t'(system_bus_wr_data[2:0]);
    end

    prescale_d = prescale_q;
    if (wr_presc) begin
      prescale_d = presc_merge[PRESC_WID-1:0];
    end

    pending_d = pending_q;
    if (match || reload) begin
      pending_d = 1'b1;
    end else if (w1c) begin
      pending_d = 1'b0;
    end

    irq_d = pending_q & ctrl_q.irq_en;

    rd_data_d   = rd_data_q;
    hi_shadow_d = hi_shadow_q;
    if (rd_en) begin
      case (offset)
        TMR_MTIME_LO: begin
          rd_data_d   = mtime_q[31:0];
          hi_shadow_d = mtime_q[63:32];
        end
        TMR_MTIME_HI:    rd_data_d = hi_shadow_q;
        TMR_MTIMECMP_LO: rd_data_d = mtimecmp_q[31:0];
        TMR_MTIMECMP_HI: rd_data_d = mtimecmp_q[63:32];
        TMR_CTRL:        rd_data_d = 32'(ctrl_q);
        TMR_STATUS:      rd_data_d = 32'(pending_q);
        TMR_PRESCALE:    rd_data_d = presc_ext;
        default:         rd_data_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= RST_CMP;
      pending_q   <= 1'b0;
      prescale_q  <= '0;
      hi_shadow_q <= '0;
      rd_data_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      pending_q   <= pending_d;
      prescale_q  <= prescale_d;
      hi_shadow_q <= hi_shadow_d;
      rd_data_q   <= rd_data_d;
      irq_q       <= irq_d;
    end
  end

  assign system_bus_rd_data = rd_data_q;
  assign irq_o              = irq_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - directed and randomized checks of timer_irq_ctrl against a cycle model
module tb_timer_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_i = 1'b0;
  logic        system_bus_en = 1'b0;
  logic        system_bus_rdwr = 1'b0;
  logic [3:0]  system_bus_mask = 4'h0;
  logic [31:0] system_bus_addr = 32'h0;
  logic [31:0] system_bus_wr_data = 32'h0;
  logic [31:0] system_bus_rd_data;
  logic        irq_o;

  always #5 clk = ~clk;

  timer_irq_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sel_i              (sel_i),
    .system_bus_en      (system_bus_en),
    .system_bus_rdwr    (system_bus_rdwr),
    .system_bus_mask    (system_bus_mask),
    .system_bus_addr    (system_bus_addr),
    .system_bus_wr_data (system_bus_wr_data),
    .system_bus_rd_data (system_bus_rd_data),
    .irq_o              (irq_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: what software would see of the timer
  logic [63:0] m_mtime, m_cmp;
  logic [2:0]  m_ctrl;
  logic        m_pend, m_irq;
  logic [15:0] m_presc, m_pcnt;
  logic [31:0] m_shadow, m_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_mtime = 64'd0; m_cmp = {64{1'b1}}; m_ctrl = 3'd0; m_pend = 1'b0; m_irq = 1'b0;
    m_presc = 16'd0; m_pcnt = 16'd0; m_shadow = 32'd0; m_rd = 32'd0;
  endtask

  task automatic model_edge(input bit acc, input bit wr, input logic [3:0] m,
                            input logic [2:0] off, input logic [31:0] wd);
    bit w, r, running, tick, reload, match, clr;
    logic [63:0] nt;
    logic [31:0] tmp;
    w = acc && wr;
    r = acc && !wr;
    running = m_ctrl[0] && !(w && off == 3'd4 && m[0] && !wd[0]);
    tick    = running && (m_pcnt == m_presc);
    reload  = tick && m_ctrl[2] && (m_mtime + 64'd1 == m_cmp);
    match   = m_ctrl[0] && (m_mtime >= m_cmp);
    clr     = w && off == 3'd5 && m[0] && wd[0];

    if (r) begin
      case (off)
        3'd0: begin m_rd = m_mtime[31:0]; end
        3'd1: m_rd = m_shadow;
        3'd2: m_rd = m_cmp[31:0];
        3'd3: m_rd = m_cmp[63:32];
        3'd4: m_rd = {29'd0, m_ctrl};
        3'd5: m_rd = {31'd0, m_pend};
        3'd6: m_rd = {16'd0, m_presc};
        default: m_rd = 32'd0;
      endcase
      if (off == 3'd0) m_shadow = m_mtime[63:32];
    end
    m_irq = m_pend && m_ctrl[1];

    nt = m_mtime;
    if (tick) nt = reload ? 64'd0 : m_mtime + 64'd1;
    if (w && off == 3'd0) nt = {m_mtime[63:32], lanes(m_mtime[31:0], wd, m)};
    if (w && off == 3'd1) nt = {lanes(m_mtime[63:32], wd, m), m_mtime[31:0]};

    if (w && off == 3'd6) m_pcnt = 16'd0;
    else if (running) m_pcnt = (m_pcnt == m_presc) ? 16'd0 : m_pcnt + 16'd1;

    if (match || reload) m_pend = 1'b1;
    else if (clr) m_pend = 1'b0;

    if (w && off == 3'd2) m_cmp[31:0]  = lanes(m_cmp[31:0], wd, m);
    if (w && off == 3'd3) m_cmp[63:32] = lanes(m_cmp[63:32], wd, m);
    if (w && off == 3'd4 && m[0]) m_ctrl = wd[2:0];
    if (w && off == 3'd6) begin
      tmp = lanes({16'd0, m_presc}, wd, m);
      m_presc = tmp[15:0];
    end
    m_mtime = nt;
  endtask

  // One bus cycle: drive at negedge, check rd_data/irq just after the edge, return at next negedge
  task automatic bus(input bit sel, input bit en, input bit wr, input logic [3:0] m,
                     input logic [2:0] off, input logic [31:0] wd);
    sel_i = sel; system_bus_en = en; system_bus_rdwr = wr; system_bus_mask = m;
    system_bus_addr = {4'hA, 23'd0, off, 2'b00}; system_bus_wr_data = wd;
    model_edge(sel && en, wr, m, off, wd);
    @(posedge clk);
    #1;
    check("rd_data", {32'd0, system_bus_rd_data}, {32'd0, m_rd});
    check("irq_o", {63'd0, irq_o}, {63'd0, m_irq});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 32'd0);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] wd, input logic [3:0] m = 4'hF);
    bus(1'b1, 1'b1, 1'b1, m, off, wd);
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] val);
    bus(1'b1, 1'b1, 1'b0, 4'h0, off, 32'd0);
    val = system_bus_rd_data;
  endtask

  task automatic rd_expect(input string tag, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] v;
    rd(off, v);
    check(tag, {32'd0, v}, {32'd0, exp});
  endtask

  logic [31:0] v, lo_v, hi_v;
  int n;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_irq", {63'd0, irq_o}, 64'd0);
    check("reset_rd", {32'd0, system_bus_rd_data}, 64'd0);
    rst_n = 1'b1;

    rd_expect("rst_mtime_lo", 3'd0, 32'h0);
    rd_expect("rst_mtime_hi", 3'd1, 32'h0);
    rd_expect("rst_cmp_lo", 3'd2, 32'hFFFF_FFFF);
    rd_expect("rst_cmp_hi", 3'd3, 32'hFFFF_FFFF);
    rd_expect("rst_ctrl", 3'd4, 32'h0);
    rd_expect("rst_status", 3'd5, 32'h0);
    rd_expect("rst_presc", 3'd6, 32'h0);
    rd_expect("rst_rsvd", 3'd7, 32'h0);

    // One-shot compare with prescale 3
    wr(3'd6, 32'd3);
    wr(3'd2, 32'd10);
    wr(3'd3, 32'd0);
    wr(3'd4, 32'd3);
    n = 0;
    while (irq_o !== 1'b1 && n < 100) begin idle(1); n++; end
    check("oneshot_irq_rise", {63'd0, irq_o}, 64'd1);
    check("oneshot_latency_min", {63'd0, (n >= 36)}, 64'd1);
    rd_expect("oneshot_status", 3'd5, 32'd1);
    wr(3'd5, 32'd1);
    rd_expect("w1c_while_match", 3'd5, 32'd1);
    wr(3'd3, 32'd1);
    wr(3'd5, 32'd1);
    idle(2);
    check("irq_dropped", {63'd0, irq_o}, 64'd0);
    rd_expect("status_cleared", 3'd5, 32'd0);

    // Periodic reload at compare 5
    wr(3'd4, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd6, 32'd0);
    wr(3'd2, 32'd5);
    wr(3'd3, 32'd0);
    wr(3'd5, 32'd1);
    wr(3'd4, 32'd7);
    for (int i = 0; i < 12; i++) begin
      rd(3'd0, v);
      check("periodic_below_cmp", {63'd0, (v < 32'd5)}, 64'd1);
    end
    n = 0;
    while (m_mtime != 64'd1 && n < 20) begin idle(1); n++; end
    check("periodic_sync", {63'd0, (n < 20)}, 64'd1);
    wr(3'd5, 32'd1);
    rd_expect("periodic_cleared", 3'd5, 32'd0);
    idle(1);
    wr(3'd5, 32'd1);
    rd_expect("w1c_on_reload", 3'd5, 32'd1);

    // Atomic 64-bit read across a carry into the high word
    wr(3'd4, 32'd0);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd5, 32'd1);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'hFFFF_FFFE);
    wr(3'd6, 32'd0);
    wr(3'd4, 32'd1);
    rd(3'd0, lo_v);
    idle(2);
    rd(3'd1, hi_v);
    check("atomic_lo", {32'd0, lo_v}, 64'hFFFF_FFFE);
    check("atomic_hi_snapshot", {32'd0, hi_v}, 64'd0);
    rd(3'd0, lo_v);
    rd(3'd1, hi_v);
    check("atomic_hi_after_carry", {32'd0, hi_v}, 64'd1);

    // Byte lanes and reserved offset
    wr(3'd4, 32'd0);
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd2, 32'hAABB_CCDD, 4'b0101);
    rd_expect("byte_mask", 3'd2, 32'hFFBB_FFDD);
    wr(3'd7, 32'h1234_5678);
    rd_expect("rsvd_after_write", 3'd7, 32'h0);

    // Asynchronous reset with the interrupt asserted
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd4, 32'd3);
    idle(3);
    check("pre_reset_irq", {63'd0, irq_o}, 64'd1);
    rd_expect("pre_reset_ctrl", 3'd4, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_irq", {63'd0, irq_o}, 64'd0);
    check("async_reset_rd", {32'd0, system_bus_rd_data}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    rd_expect("post_reset_frozen", 3'd0, 32'd0);
    wr(3'd4, 32'd1);
    idle(3);
    rd(3'd0, v);
    check("post_reset_counting", {63'd0, (v != 32'd0)}, 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [2:0]  off;
      logic [31:0] wd;
      logic [3:0]  m;
      off = 3'($urandom_range(0, 7));
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      case (off)
        3'd0: wd = $urandom_range(0, 30);
        3'd1: wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
        3'd2: wd = $urandom_range(0, 40);
        3'd3: wd = ($urandom_range(0, 5) == 0) ? 32'd1 : 32'd0;
        3'd4: wd = $urandom_range(0, 7);
        3'd6: wd = $urandom_range(0, 3);
        default: wd = $urandom;
      endcase
      bus($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
          m, off, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Memory-mapped machine timer and interrupt source on the system bus, decoded at base 0xA0000000.
- Drives the `interupt` input of the main_csr_pipe core. Upstream of the core's interrupt path; a peer of memory, gemm and uart on the bus.
- Contains a 64-bit prescaled counter (MTIME), a 64-bit compare value (MTIMECMP), a sticky pending flag, and one-shot or periodic modes.

Parameters:
- PRESC_WID, 16, width of the prescaler register and counter.
- RST_CMP, 64'hFFFF_FFFF_FFFF_FFFF, reset value of MTIMECMP (no match after reset).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- sel_i  input  1  address decode select (addr[31:28]==4'hA), from top
- system_bus_en  input  1  bus request
- system_bus_rdwr  input  1  1 = write, 0 = read
- system_bus_mask  input  4  byte enables for writes
- system_bus_addr  input  32  word-aligned address; only [4:2] used
- system_bus_wr_data  input  32  write data
- system_bus_rd_data  output  32  registered read data
- irq_o  output  1  level interrupt to core, = pending & irq_en

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: mtime=0; mtimecmp=RST_CMP; ctrl=0; pending=0; prescale=0; presc_cnt=0; hi_shadow=0; system_bus_rd_data=0; irq_o=0.
- Access qualifiers: acc = system_bus_en & sel_i. Write = acc & rdwr. Read = acc & ~rdwr.
- Register map (offset = addr[4:2]):
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 CTRL: bit0 en, bit1 irq_en, bit2 periodic
  - 5 STATUS: bit0 pending, write-1-to-clear
  - 6 PRESCALE: [PRESC_WID-1:0]
  - 7 reserved: reads 0, writes ignored
- Writes: take effect at the clock edge of the request. Each byte lane is written only if its mask bit is set. Bits beyond a register's width are ignored.
- Reads: system_bus_rd_data is loaded at the edge of the request and valid the following cycle, matching the top-level mem_valid timing. It holds its value when there is no read.
- Atomic 64-bit read:
  - Reading MTIME_LO returns mtime[31:0] and copies mtime[63:32] into hi_shadow in the same edge.
  - Reading MTIME_HI returns hi_shadow, not live mtime.
  - MTIMECMP reads are live.
- Prescaler:
  - When en=1: presc_cnt increments every cycle. When presc_cnt==prescale, presc_cnt returns to 0 and mtime increments by 1.
  - prescale=0 gives one tick per cycle.
  - en=0 freezes both presc_cnt and mtime.
  - Writing PRESCALE clears presc_cnt.
- Counter wrap: mtime wraps from 2^64-1 to 0 without setting any flag.
- Match and pending:
  - match = en & (mtime >= mtimecmp), evaluated on registered values.
  - On a cycle with match, pending is set to 1.
  - One-shot mode (periodic=0): pending stays set while match holds; mtime keeps counting.
  - Periodic mode (periodic=1): on a tick where the incremented value would reach mtimecmp, mtime loads 0 instead, and pending is set on that same edge.
- Interrupt output: irq_o is registered, so it follows pending & irq_en one cycle later. It stays high until software clears pending. If a match still holds, pending is set again on the next cycle.
- Priorities when events coincide:
  - Software write to MTIME_LO/HI beats a tick increment or periodic reload in the same cycle. Non-written bytes keep their pre-increment value.
  - Pending set (match) beats a W1C clear in the same cycle.
  - Writing CTRL.en=0 takes effect immediately: a tick in that same cycle is suppressed.
- Reset asserted mid-operation: all state returns to reset values immediately. No bus response is produced for a request in flight.
- Non-selected accesses (sel_i=0): no state change and rd_data unchanged. The top level muxes rd_data using a registered select.

Decomposition:
- Package timer_pkg:
  - offset localparams TMR_MTIME_LO..TMR_PRESCALE;
  - CTRL bit indices;
  - typedef struct packed {logic periodic, irq_en, en;} tmr_ctrl_t;
  - base-address constant 4'hA for top decode.
- Sub-module timer_prescaler (presc_cnt, clear, enable; outputs a tick pulse).
- Register file, shadow, compare and irq logic live in the top module.

Test Plan:
- Reset, then read every offset: MTIME=0, MTIMECMP=FFFF_FFFF/FFFF_FFFF, CTRL=0, STATUS=0, irq_o=0. Each rd_data is valid one cycle after its request.
- PRESCALE=3, MTIMECMP=10, CTRL=3 → mtime ticks every 4 cycles; pending=1 when mtime=10 (~40 cycles); irq_o high the next cycle. Writing STATUS=1 does not clear pending while the match holds. Setting MTIMECMP_HI=1 then W1C → irq_o drops.
- Periodic: PRESCALE=0, MTIMECMP=5, CTRL=7 → mtime sequence 0,1,2,3,4,0,1,…; pending set on each reload edge. A W1C in the same cycle as a reload leaves pending=1.
- Atomic read: MTIME_HI=0, MTIME_LO=FFFF_FFFE, PRESCALE=0, en=1. Read LO, then read HI 3 cycles later. The HI value equals the snapshot taken with LO (0 or 1 consistent with LO), not the live value.
- Byte mask: write MTIMECMP_LO=AABBCCDD with mask 4'b0101 over FFFFFFFF → readback FFBBFFDD. A write to offset 7 followed by a read returns 0.
- Assert rst_n low mid-count with irq_o=1 → outputs go to 0 asynchronously. After release, mtime restarts from 0 only once CTRL.en is written.
